// File: rtl/instruction_fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding,
// default reset PC, sequential increment and address alignment.
package instruction_fetch_stage_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_INCR_DEFAULT  = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Instruction-memory handshake plus IF/ID-facing signals of the fetch stage.
// master = fetch stage view, slave = memory / pipeline view.
interface instruction_fetch_stage_if;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemReady;
  logic [31:0] IMemData;
  logic        Consume;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic        FetchValid;
  logic [31:0] InstructionOut;
  logic [31:0] PCOut;
  logic [31:0] PCAddedOut;

  modport master (
    output IMemReq, IMemAddr, FetchValid, InstructionOut, PCOut, PCAddedOut,
    input  IMemReady, IMemData, Consume, Redirect, RedirectTarget
  );

  modport slave (
    input  IMemReq, IMemAddr, FetchValid, InstructionOut, PCOut, PCAddedOut,
    output IMemReady, IMemData, Consume, Redirect, RedirectTarget
  );
endinterface

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: owns the PC, issues instruction-memory requests and buffers
// one instruction (with PC and PC+4) until IF/ID consumes it.
//
// state   | meaning
// IDLE    | one cycle after reset release, no request
// FETCH   | normal fetching and buffering
// DISCARD | redirected while a request was outstanding; finish it, drop data
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] PC_INCR  = PC_INCR_DEFAULT
) (
  input  logic                       Clk,
  input  logic                       Reset,
  instruction_fetch_stage_if.master  bus
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc, held_addr;
  logic         req_active;
  logic         fetch_valid;
  logic [31:0]  instr_q, pc_q, pc_added_q;

  logic         req;
  logic [31:0]  addr;
  logic         capture;
  logic         outstanding;

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    addr      = pc;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        req = req_active || !fetch_valid || bus.Consume;
        if (bus.Redirect && req && !bus.IMemReady) state_nxt = DISCARD;
      end
      DISCARD: begin
        // address must stay stable until the abandoned request is accepted
        req  = 1'b1;
        addr = held_addr;
        if (bus.IMemReady) state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign capture     = (state == FETCH) && req && bus.IMemReady && !bus.Redirect;
  assign outstanding = (state == FETCH) && req && !bus.IMemReady;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      held_addr   <= 32'h0;
      req_active  <= 1'b0;
      fetch_valid <= 1'b0;
      instr_q     <= 32'h0;
      pc_q        <= 32'h0;
      pc_added_q  <= 32'h0;
    end else begin
      state      <= state_nxt;
      req_active <= req && !bus.IMemReady;
      if (bus.Redirect && state != IDLE) begin
        fetch_valid <= 1'b0;
        pc          <= word_align(bus.RedirectTarget);
        if (outstanding) held_addr <= pc;
      end else if (capture) begin
        instr_q     <= bus.IMemData;
        pc_q        <= pc;
        pc_added_q  <= pc + PC_INCR;
        fetch_valid <= 1'b1;
        pc          <= pc + PC_INCR;
      end else if (bus.Consume) begin
        fetch_valid <= 1'b0;
      end
    end
  end

  assign bus.IMemReq        = req;
  assign bus.IMemAddr       = addr;
  assign bus.FetchValid     = fetch_valid;
  assign bus.InstructionOut = instr_q;
  assign bus.PCOut          = pc_q;
  assign bus.PCAddedOut     = pc_added_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage; memory returns addr ^ A5A5_0000.
module tb_instruction_fetch_stage;
  logic Clk;
  logic Reset;
  int   total;
  int   bad;

  instruction_fetch_stage_if bus ();

  instruction_fetch_stage dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  assign bus.IMemData = bus.IMemAddr ^ 32'hA5A5_0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_buf(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'h0, bus.FetchValid}, 32'h1);
    chk({tag, "_pc"}, bus.PCOut, pc);
    chk({tag, "_pcadd"}, bus.PCAddedOut, pc + 32'd4);
    chk({tag, "_instr"}, bus.InstructionOut, pc ^ 32'hA5A5_0000);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    Reset = 1'b0;
    bus.IMemReady      = 1'b0;
    bus.Consume        = 1'b0;
    bus.Redirect       = 1'b0;
    bus.RedirectTarget = 32'h0;

    // reset and streaming
    repeat (3) tick();
    chk("rst_valid", {31'h0, bus.FetchValid}, 32'h0);
    chk("rst_req", {31'h0, bus.IMemReq}, 32'h0);
    chk("rst_pc", bus.PCOut, 32'h0);
    chk("rst_pcadd", bus.PCAddedOut, 32'h0);
    chk("rst_instr", bus.InstructionOut, 32'h0);
    Reset = 1'b1;
    bus.IMemReady = 1'b1;
    bus.Consume   = 1'b1;
    #1;
    chk("idle_req", {31'h0, bus.IMemReq}, 32'h0);
    tick();
    chk("first_req", {31'h0, bus.IMemReq}, 32'h1);
    chk("first_addr", bus.IMemAddr, 32'h0);
    chk("first_valid", {31'h0, bus.FetchValid}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_buf("stream", 32'(4 * k));
      chk("stream_addr", bus.IMemAddr, 32'(4 * k + 4));
    end

    // stall with PCOut=8 buffered
    bus.Consume = 1'b0;
    #1;
    chk("stall_req", {31'h0, bus.IMemReq}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_buf("stall", 32'h8);
      chk("stall_req", {31'h0, bus.IMemReq}, 32'h0);
    end
    bus.Consume = 1'b1;
    tick();
    chk_buf("unstall", 32'hC);

    // slow memory on 0x10
    bus.IMemReady = 1'b0;
    tick();
    chk("slow_valid", {31'h0, bus.FetchValid}, 32'h0);
    chk("slow_req", {31'h0, bus.IMemReq}, 32'h1);
    chk("slow_addr", bus.IMemAddr, 32'h10);
    tick();
    chk("slow_req2", {31'h0, bus.IMemReq}, 32'h1);
    chk("slow_addr2", bus.IMemAddr, 32'h10);
    bus.IMemReady = 1'b1;
    tick();
    chk_buf("slow_cap", 32'h10);

    // redirect while 0x20 outstanding
    repeat (3) tick();
    chk_buf("pre_redir", 32'h1C);
    bus.IMemReady = 1'b0;
    tick();
    chk("out_addr", bus.IMemAddr, 32'h20);
    bus.Redirect       = 1'b1;
    bus.RedirectTarget = 32'h103;
    tick();
    bus.Redirect = 1'b0;
    #1;
    chk("disc_valid", {31'h0, bus.FetchValid}, 32'h0);
    chk("disc_req", {31'h0, bus.IMemReq}, 32'h1);
    chk("disc_addr", bus.IMemAddr, 32'h20);
    tick();
    chk("disc_addr2", bus.IMemAddr, 32'h20);
    bus.IMemReady = 1'b1;
    tick();
    chk("drop_valid", {31'h0, bus.FetchValid}, 32'h0);
    chk("after_disc_addr", bus.IMemAddr, 32'h100);
    tick();
    chk_buf("redir_cap", 32'h100);

    // redirect with completing request, then redirect+consume on valid 0x40
    bus.Redirect       = 1'b1;
    bus.RedirectTarget = 32'h40;
    tick();
    bus.Redirect = 1'b0;
    #1;
    chk("done_redir_valid", {31'h0, bus.FetchValid}, 32'h0);
    chk("done_redir_addr", bus.IMemAddr, 32'h40);
    tick();
    chk_buf("at40", 32'h40);
    bus.Redirect       = 1'b1;
    bus.RedirectTarget = 32'h200;
    tick();
    bus.Redirect = 1'b0;
    #1;
    chk("rc_valid", {31'h0, bus.FetchValid}, 32'h0);
    chk("rc_addr", bus.IMemAddr, 32'h200);
    tick();
    chk_buf("rc_cap", 32'h200);

    // wrap-around
    bus.Redirect       = 1'b1;
    bus.RedirectTarget = 32'hFFFF_FFFE;
    tick();
    bus.Redirect = 1'b0;
    #1;
    chk("wrap_addr", bus.IMemAddr, 32'hFFFF_FFFC);
    tick();
    chk_buf("wrap_cap", 32'hFFFF_FFFC);
    chk("wrap_next", bus.IMemAddr, 32'h0);

    // async reset mid-DISCARD
    bus.IMemReady = 1'b0;
    tick();
    bus.Redirect       = 1'b1;
    bus.RedirectTarget = 32'h80;
    tick();
    bus.Redirect = 1'b0;
    #1;
    chk("pre_rst_addr", bus.IMemAddr, 32'h0);
    chk("pre_rst_req", {31'h0, bus.IMemReq}, 32'h1);
    #1;
    Reset = 1'b0;
    #1;
    chk("arst_req", {31'h0, bus.IMemReq}, 32'h0);
    chk("arst_valid", {31'h0, bus.FetchValid}, 32'h0);
    chk("arst_pc", bus.PCOut, 32'h0);
    chk("arst_pcadd", bus.PCAddedOut, 32'h0);
    chk("arst_instr", bus.InstructionOut, 32'h0);
    tick();
    bus.IMemReady = 1'b1;
    Reset = 1'b1;
    #1;
    chk("rel_req", {31'h0, bus.IMemReq}, 32'h0);
    tick();
    chk("rel_valid", {31'h0, bus.FetchValid}, 32'h0);
    chk("rel_addr", bus.IMemAddr, 32'h0);
    tick();
    chk_buf("rel_cap", 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
